fight_round_sequencer: RTL

- Sequences a best-of-N match while the top-level game state is in the fight state.
- Runs the round intro countdown, the round timer, KO and timeout detection, the post-KO hold and the round and win counters.
- Drives game_over and the match winner back to the game state controller.
- Gates player controls through inputs_enable and pulses round_start so the health logic reloads HP.

---
 rtl/fight_pkg.sv | 30 +++
 rtl/fight_round_sequencer_sec_countdown.sv | 47 ++++
 rtl/fight_round_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fight_pkg.sv
// ============================================================================
// fight_pkg : round state encodings, winner codes and timer width shared by
//             the fight round sequencer.            Revision: 1.0
// ============================================================================
`default_nettype none

package fight_pkg;

  localparam int TIMER_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INTRO     = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_KO        = 3'd3,
    ST_MATCH_END = 3'd4
  } round_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fight_round_sequencer_sec_countdown.sv
// ============================================================================
// sec_countdown : loadable seconds down-counter with expiry pulse, shared by
//                 the intro, fight and KO phases.       Revision: 1.0
// ============================================================================
`default_nettype none

module sec_countdown
  import fight_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  input  logic               hold,
  output logic [TIMER_W-1:0] count,
  output logic               expire_pulse
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;
  logic               tick_ok;

  always_comb begin
    tick_ok = tick && !hold;
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick_ok && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count        = count_q;
  assign expire_pulse = tick_ok && (count_q == TIMER_W'(1));

endmodule

`default_nettype wire

// File: rtl/fight_round_sequencer.sv
// ============================================================================
// fight_round_sequencer : best-of-N round/match sequencer for the fight state.
//   Optional pause input enabled by defining FIGHT_PAUSE_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module fight_round_sequencer
  import fight_pkg::*;
#(
  parameter int HP_W            = 8,
  parameter int ROUND_SECONDS   = 99,
  parameter int INTRO_SECONDS   = 3,
  parameter int KO_HOLD_SECONDS = 2,
  parameter int ROUNDS_TO_WIN   = 2,
  parameter int MAX_ROUNDS      = 5
) (
  input  logic            clk,
  input  logic            reset,
`ifdef FIGHT_PAUSE_EN
  input  logic            pause,
`endif
  input  logic            fight_active,
  input  logic            sec_tick,
  input  logic [HP_W-1:0] p1_hp,
  input  logic [HP_W-1:0] p2_hp,
  output logic [2:0]      round_state,
  output logic [2:0]      round_num,
  output logic [6:0]      timer_sec,
  output logic [1:0]      p1_wins,
  output logic [1:0]      p2_wins,
  output logic            inputs_enable,
  output logic            round_start,
  output logic            game_over,
  output logic [1:0]      winner
);

  localparam logic [TIMER_W-1:0] ROUND_LOAD = TIMER_W'(ROUND_SECONDS);
  localparam logic [TIMER_W-1:0] INTRO_LOAD = TIMER_W'(INTRO_SECONDS);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(KO_HOLD_SECONDS);
  localparam logic [1:0]         WINS_NEED  = 2'(ROUNDS_TO_WIN);
  localparam logic [2:0]         LAST_ROUND = 3'(MAX_ROUNDS);

  round_state_t state_q, state_d;
  logic [2:0]   round_num_q, round_num_d;
  logic [1:0]   p1_wins_q, p1_wins_d;
  logic [1:0]   p2_wins_q, p2_wins_d;
  logic         inputs_enable_q, inputs_enable_d;
  logic         round_start_q, round_start_d;
  logic         game_over_q, game_over_d;
  logic [1:0]   winner_q, winner_d;

  logic               cnt_load;
  logic [TIMER_W-1:0] cnt_load_val;
  logic [TIMER_W-1:0] cnt_count;
  logic               cnt_expire;
  logic               pause_act;
  logic               round_end;
  logic [1:0]         round_win;

`ifdef FIGHT_PAUSE_EN
  assign pause_act = pause && ((state_q == ST_INTRO) || (state_q == ST_FIGHT) ||
                               (state_q == ST_KO));
`else
  assign pause_act = 1'b0;
`endif

  sec_countdown u_countdown (
    .clk          (clk),
    .reset        (reset),
    .load         (cnt_load),
    .load_val     (cnt_load_val),
    .tick         (sec_tick),
    .hold         (pause_act),
    .count        (cnt_count),
    .expire_pulse (cnt_expire)
  );

  always_comb begin
    state_d         = state_q;
    round_num_d     = round_num_q;
    p1_wins_d       = p1_wins_q;
    p2_wins_d       = p2_wins_q;
    inputs_enable_d = inputs_enable_q;
    round_start_d   = 1'b0;
    game_over_d     = game_over_q;
    winner_d        = winner_q;
    cnt_load        = 1'b0;
    cnt_load_val    = '0;
    round_end       = 1'b0;
    round_win       = WIN_NONE;

    // Leaving the fight state from anywhere but IDLE wipes the whole match.
    if ((state_q != ST_IDLE) && !fight_active) begin
      state_d         = ST_IDLE;
      round_num_d     = '0;
      p1_wins_d       = '0;
      p2_wins_d       = '0;
      inputs_enable_d = 1'b0;
      game_over_d     = 1'b0;
      winner_d        = WIN_NONE;
      cnt_load        = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fight_active) begin
            state_d       = ST_INTRO;
            round_num_d   = 3'd1;
            p1_wins_d     = '0;
            p2_wins_d     = '0;
            round_start_d = 1'b1;
            game_over_d   = 1'b0;
            winner_d      = WIN_NONE;
            cnt_load      = 1'b1;
            cnt_load_val  = INTRO_LOAD;
          end
        end

        ST_INTRO: begin
          if (!pause_act && cnt_expire) begin
            state_d         = ST_FIGHT;
            inputs_enable_d = 1'b1;
            cnt_load        = 1'b1;
            cnt_load_val    = ROUND_LOAD;
          end
        end

        ST_FIGHT: begin
          if (!pause_act) begin
            // KO checks come first so a KO on the final second beats timeout.
            if ((p1_hp == '0) && (p2_hp == '0)) begin
              round_end = 1'b1;
              round_win = WIN_DRAW;
            end else if (p1_hp == '0) begin
              round_end = 1'b1;
              round_win = WIN_P2;
            end else if (p2_hp == '0) begin
              round_end = 1'b1;
              round_win = WIN_P1;
            end else if (cnt_expire) begin
              round_end = 1'b1;
              round_win = (p1_hp > p2_hp) ? WIN_P1 :
                          (p2_hp > p1_hp) ? WIN_P2 : WIN_DRAW;
            end

            if (round_end) begin
              if (round_win == WIN_P1) p1_wins_d = sat_inc2(p1_wins_q);
              if (round_win == WIN_P2) p2_wins_d = sat_inc2(p2_wins_q);
              state_d         = ST_KO;
              inputs_enable_d = 1'b0;
              cnt_load        = 1'b1;
              cnt_load_val    = HOLD_LOAD;
            end
          end
        end

        ST_KO: begin
          if (!pause_act && cnt_expire) begin
            cnt_load = 1'b1;
            if (p1_wins_q >= WINS_NEED) begin
              state_d     = ST_MATCH_END;
              game_over_d = 1'b1;
              winner_d    = WIN_P1;
            end else if (p2_wins_q >= WINS_NEED) begin
              state_d     = ST_MATCH_END;
              game_over_d = 1'b1;
              winner_d    = WIN_P2;
            end else if (round_num_q == LAST_ROUND) begin
              state_d     = ST_MATCH_END;
              game_over_d = 1'b1;
              winner_d    = (p1_wins_q > p2_wins_q) ? WIN_P1 :
                            (p2_wins_q > p1_wins_q) ? WIN_P2 : WIN_DRAW;
            end else begin
              state_d       = ST_INTRO;
              round_num_d   = round_num_q + 3'd1;
              round_start_d = 1'b1;
              cnt_load_val  = INTRO_LOAD;
            end
          end
        end

        ST_MATCH_END: begin
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      round_num_q     <= '0;
      p1_wins_q       <= '0;
      p2_wins_q       <= '0;
      inputs_enable_q <= 1'b0;
      round_start_q   <= 1'b0;
      game_over_q     <= 1'b0;
      winner_q        <= WIN_NONE;
    end else begin
      state_q         <= state_d;
      round_num_q     <= round_num_d;
      p1_wins_q       <= p1_wins_d;
      p2_wins_q       <= p2_wins_d;
      inputs_enable_q <= inputs_enable_d;
      round_start_q   <= round_start_d;
      game_over_q     <= game_over_d;
      winner_q        <= winner_d;
    end
  end

  assign round_state   = state_q;
  assign round_num     = round_num_q;
  assign timer_sec     = cnt_count;
  assign p1_wins       = p1_wins_q;
  assign p2_wins       = p2_wins_q;
  assign inputs_enable = inputs_enable_q && !pause_act;
  assign round_start   = round_start_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

`default_nettype wire
